divider: RTL and testbench
==========================

# divider

Iterative 32-bit integer divider for the out-of-order core's execute stage, sitting beside the pipelined multiplier as the inverse arithmetic unit. It accepts one divide per issue from its reservation station, runs a radix-2 restoring algorithm over 32 iterations, then broadcasts quotient or remainder with the instruction's destination tag and register onto the same writeback/CDB path the multiplier uses. It is not pipelined. Issue logic must hold further divides while `busy` is high.

## Interface
Parameters: none (width fixed at 32).

Ports:
- `clk`  input  1  — clock, rising-edge
- `reset`  input  1  — asynchronous, active-high; clears all state
- `start`  input  1  — issue valid; accepted only when `busy`=0
- `A`  input  32  — dividend
- `B`  input  32  — divisor
- `is_signed`  input  1  — 1: two's-complement operands; 0: unsigned
- `want_rem`  input  1  — 1: return remainder; 0: return quotient
- `dst_tag`  input  5  — ROB/rename tag of the issuing instruction
- `dst`  input  5  — architectural destination register
- `wr_en`  input  1  — instruction writes a register
- `busy`  output  1  — unit occupied; `start` ignored
- `done_div`  output  1  — one-cycle completion pulse
- `result`  output  32  — quotient or remainder
- `dst_tag_div`  output  5  — tag of the completing instruction
- `dst_div`  output  5  — destination of the completing instruction
- `wr_en_div`  output  1  — latched `wr_en` qualified by `done_div`

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on `start`=1, latch `dst_tag`, `dst`, `wr_en`, `want_rem`, and `is_signed`. Latch the operand signs (`A[31]`, `B[31]` when signed, else 0) and the original `A`. Load dividend magnitude into the quotient shift register. Load divisor magnitude. Clear the 33-bit partial remainder and the 5-bit iteration counter. Go to RUN.
- RUN, each cycle:
  - remainder = {remainder[31:0], quotient[31]}; shift the quotient left.
  - If remainder ≥ divisor, subtract the divisor and set quotient bit 0 to 1.
  - The counter increments. After the 32nd iteration (counter wraps 31→0), go to FIX.
- FIX, one cycle, registering outputs:
  - Divisor zero: quotient = 0xFFFFFFFF and remainder = original `A`, for both signed and unsigned.
  - Signed: negate the quotient if the operand signs differ. Negate the remainder if the dividend was negative.
  - Signed overflow (0x80000000 / 0xFFFFFFFF) falls out naturally as quotient 0x80000000, remainder 0. No special path.
  - `result` ← remainder if `want_rem`, else quotient.
  - `done_div` ← 1. `wr_en_div` ← latched `wr_en`. Tag and destination driven from the latches. Go to IDLE.
- `busy` = 1 in RUN and FIX.
- `start` while `busy`=1 is ignored; no queueing and no error flag.
- A `start` in the cycle `done_div` is high is accepted (back-to-back).
- `result`, `dst_tag_div`, and `dst_div` hold their last values until the next FIX. `wr_en_div` and `done_div` are 0 outside the pulse.

## Timing
- Reset values: `busy`=0, `done_div`=0, `wr_en_div`=0, `result`=0, `dst_tag_div`=0, `dst_div`=0, state IDLE. Takes effect immediately, not at the next edge.
- Accept edge = E0. RUN iterations occur at E1..E32. FIX registers outputs at E33.
- `done_div` is high for exactly one cycle, from E33 to E34. Latency is fixed at 33 cycles for all operands, including divide-by-zero.
- `busy` rises after E0 and falls after E33, the same edge on which `done_div` rises.
- Reset asserted mid-RUN or FIX aborts the operation. No `done_div` is produced for it.
- Inputs other than `start` are sampled only at the accept edge. They may change freely while `busy`=1.

## Test plan
- Unsigned 100 / 7, `want_rem`=0 → `result`=14 at E33; repeat with `want_rem`=1 → 2. Check `done_div` is exactly one cycle and `dst_tag_div`/`dst_div` equal the issued values.
- Signed −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Signed 7 / −2 → quotient −3, remainder 1.
- Divide by zero, `A`=0x12345678, `B`=0: quotient 0xFFFFFFFF, remainder 0x12345678, for both signed and unsigned. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Back-to-back: second `start` raised in the `done_div` cycle is accepted; its result appears 33 cycles later. A `start` pulsed at E5 of a running op is ignored, with no extra `done_div`.
- Assert `reset` asynchronously at E10 of an operation → all outputs return to 0 immediately and `busy`=0. A new op issued after reset completes correctly. Also check `wr_en`=0 yields `done_div`=1 with `wr_en_div`=0.

Source files
------------

// File: rtl/divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : divider_if                                                |
// | Purpose  : Issue / writeback bundle between the divide reservation   |
// |            station and the iterative divider.                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface divider_if;
  // Issue side
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        is_signed;
  logic        want_rem;
  logic [4:0]  dst_tag;
  logic [4:0]  dst;
  logic        wr_en;
  // Status / writeback side
  logic        busy;
  logic        done_div;
  logic [31:0] result;
  logic [4:0]  dst_tag_div;
  logic [4:0]  dst_div;
  logic        wr_en_div;

  // Issuer drives the operation, the divider drives status and writeback
  modport master (
    output start, A, B, is_signed, want_rem, dst_tag, dst, wr_en,
    input  busy, done_div, result, dst_tag_div, dst_div, wr_en_div
  );

  modport slave (
    input  start, A, B, is_signed, want_rem, dst_tag, dst, wr_en,
    output busy, done_div, result, dst_tag_div, dst_div, wr_en_div
  );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : divider                                                   |
// | Purpose  : Non-pipelined 32-bit radix-2 restoring divider with       |
// |            signed/unsigned support, quotient or remainder result,    |
// |            and tagged one-cycle writeback pulse.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module divider (
  input  wire logic  clk,
  input  wire logic  reset,
  divider_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Operation latches captured at the accept edge
  logic [4:0]  tag_q;
  logic [4:0]  dst_q;
  logic        wr_en_q;
  logic        want_rem_q;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_orig;

  // Iteration datapath
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divisor;
  logic [4:0]  count;

  // Registered writeback outputs
  logic        done_r;
  logic        wr_en_div_r;
  logic [31:0] result_r;
  logic [4:0]  dst_tag_div_r;
  logic [4:0]  dst_div_r;

  // Combinational helpers
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes; unsigned operands pass straight through
  assign a_mag = (bus.is_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
  assign b_mag = (bus.is_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;

  // The partial remainder is conceptually 33 bits wide only right after the
  // shift; once the trial subtraction is resolved it always fits in 32 bits,
  // so only 32 bits are stored.
  assign rem_shift = {rem, quo[31]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});
  assign rem_sub   = rem_shift[31:0] - divisor;

  // Final sign/zero-divisor correction applied during FIX
  always_comb begin
    quo_fix = quo;
    rem_fix = rem;
    if (divisor == 32'd0) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = a_orig;
    end else begin
      if (sign_a ^ sign_b) quo_fix = ~quo + 32'd1;
      if (sign_a)          rem_fix = ~rem + 32'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, restoring iterations and writeback registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q         <= 5'd0;
      dst_q         <= 5'd0;
      wr_en_q       <= 1'b0;
      want_rem_q    <= 1'b0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      a_orig        <= 32'd0;
      quo           <= 32'd0;
      rem           <= 32'd0;
      divisor       <= 32'd0;
      count         <= 5'd0;
      done_r        <= 1'b0;
      wr_en_div_r   <= 1'b0;
      result_r      <= 32'd0;
      dst_tag_div_r <= 5'd0;
      dst_div_r     <= 5'd0;
    end else begin
      done_r      <= 1'b0;
      wr_en_div_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tag_q      <= bus.dst_tag;
            dst_q      <= bus.dst;
            wr_en_q    <= bus.wr_en;
            want_rem_q <= bus.want_rem;
            sign_a     <= bus.is_signed & bus.A[31];
            sign_b     <= bus.is_signed & bus.B[31];
            a_orig     <= bus.A;
            quo        <= a_mag;
            divisor    <= b_mag;
            rem        <= 32'd0;
            count      <= 5'd0;
          end
        end
        RUN: begin
          rem   <= rem_ge ? rem_sub : rem_shift[31:0];
          quo   <= {quo[30:0], rem_ge};
          count <= count + 5'd1;
        end
        FIX: begin
          result_r      <= want_rem_q ? rem_fix : quo_fix;
          done_r        <= 1'b1;
          wr_en_div_r   <= wr_en_q;
          dst_tag_div_r <= tag_q;
          dst_div_r     <= dst_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done_div    = done_r;
  assign bus.wr_en_div   = wr_en_div_r;
  assign bus.result      = result_r;
  assign bus.dst_tag_div = dst_tag_div_r;
  assign bus.dst_div     = dst_div_r;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_divider                                                |
// | Purpose  : Self-checking bench for divider: arithmetic reference     |
// |            model with per-cycle compare plus directed literal cases. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_divider;

  logic clk;
  logic reset;
  divider_if bus();

  divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain 64-bit division, truncating toward zero
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
    longint sa, sb, q, rm;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q  = sa / sb;
    rm = sa % sb;
    return r ? rm[31:0] : q[31:0];
  endfunction

  // Model state: one outstanding operation, completing 33 edges after accept
  int          cyc = 0;
  bit          pend = 1'b0;
  int          pend_done = 0;
  logic [31:0] pend_res;
  logic [4:0]  pend_tag, pend_dst;
  logic        pend_wr;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_tag = 5'd0, last_dst = 5'd0;

  // Model acceptance on each clock edge
  always @(posedge clk) begin
    cyc++;
    if (!reset && bus.start && (!pend || cyc > pend_done)) begin
      pend      = 1'b1;
      pend_done = cyc + 33;
      pend_res  = model_div(bus.A, bus.B, bus.is_signed, bus.want_rem);
      pend_tag  = bus.dst_tag;
      pend_dst  = bus.dst;
      pend_wr   = bus.wr_en;
    end
  end

  // Model reset: abandon any operation, outputs back to zero
  always @(posedge reset) begin
    pend     = 1'b0;
    last_res = 32'd0;
    last_tag = 5'd0;
    last_dst = 5'd0;
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    bit exp_done;
    exp_done = pend && (cyc == pend_done);
    if (exp_done) begin
      last_res = pend_res;
      last_tag = pend_tag;
      last_dst = pend_dst;
    end
    check("cyc_busy",      {31'd0, bus.busy},      {31'd0, pend && (cyc < pend_done)});
    check("cyc_done",      {31'd0, bus.done_div},  {31'd0, exp_done});
    check("cyc_wr_en_div", {31'd0, bus.wr_en_div}, {31'd0, exp_done && pend_wr});
    check("cyc_result",    bus.result,             last_res);
    check("cyc_tag",       {27'd0, bus.dst_tag_div}, {27'd0, last_tag});
    check("cyc_dst",       {27'd0, bus.dst_div},     {27'd0, last_dst});
  end

  int  lat;
  bit  got;

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                       input logic [4:0] tag, input logic [4:0] d, input logic wr);
    bus.start     = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.is_signed = s;
    bus.want_rem  = r;
    bus.dst_tag   = tag;
    bus.dst       = d;
    bus.wr_en     = wr;
  endtask

  // Release start and scramble the other inputs to show they are not resampled
  task automatic release_start();
    bus.start     = 1'b0;
    bus.A         = $urandom;
    bus.B         = $urandom;
    bus.is_signed = 1'($urandom);
    bus.want_rem  = 1'($urandom);
    bus.dst_tag   = 5'($urandom);
    bus.dst       = 5'($urandom);
    bus.wr_en     = 1'($urandom);
  endtask

  // Wait (bounded) for done_div; lat counts negedges after the accept negedge
  task automatic wait_done(input string name);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done_div) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done_div got 0 expected 1", name);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic r, input logic [4:0] tag,
                        input logic [4:0] d, input logic wr, input logic [31:0] exp);
    @(negedge clk);
    drive(a, b, s, r, tag, d, wr);
    @(negedge clk);
    release_start();
    wait_done(name);
    if (got) begin
      check({name, "_result"},  bus.result, exp);
      check({name, "_tag"},     {27'd0, bus.dst_tag_div}, {27'd0, tag});
      check({name, "_dst"},     {27'd0, bus.dst_div},     {27'd0, d});
      check({name, "_wr"},      {31'd0, bus.wr_en_div},   {31'd0, wr});
      check({name, "_latency"}, 32'(lat), 32'd32);
      @(negedge clk);
      check({name, "_pulse"},   {31'd0, bus.done_div}, 32'd0);
    end
  endtask

  int dones;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.is_signed = 1'b0; bus.want_rem = 1'b0;
    bus.dst_tag = '0; bus.dst = '0; bus.wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, bus.busy},     32'd0);
    check("rst_done",   {31'd0, bus.done_div}, 32'd0);
    check("rst_result", bus.result,            32'd0);
    #2 reset = 1'b0;

    // Basic arithmetic, hand-computed
    run_op("u100d7_q",   32'd100, 32'd7, 1'b0, 1'b0, 5'd3, 5'd7, 1'b1, 32'd14);
    run_op("u100d7_r",   32'd100, 32'd7, 1'b0, 1'b1, 5'd4, 5'd8, 1'b1, 32'd2);
    run_op("s_m7d2_q",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd5, 5'd9, 1'b1, 32'hFFFF_FFFD);
    run_op("s_m7d2_r",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd6, 5'd10, 1'b1, 32'hFFFF_FFFF);
    run_op("s_7dm2_q",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd7, 5'd11, 1'b1, 32'hFFFF_FFFD);
    run_op("s_7dm2_r",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 5'd8, 5'd12, 1'b1, 32'd1);
    // Divide by zero, both signednesses
    run_op("u_dz_q",     32'h1234_5678, 32'd0, 1'b0, 1'b0, 5'd9, 5'd13, 1'b1, 32'hFFFF_FFFF);
    run_op("u_dz_r",     32'h1234_5678, 32'd0, 1'b0, 1'b1, 5'd10, 5'd14, 1'b1, 32'h1234_5678);
    run_op("s_dz_q",     32'h1234_5678, 32'd0, 1'b1, 1'b0, 5'd11, 5'd15, 1'b1, 32'hFFFF_FFFF);
    run_op("s_dz_r",     32'h1234_5678, 32'd0, 1'b1, 1'b1, 5'd12, 5'd16, 1'b1, 32'h1234_5678);
    // Signed overflow
    run_op("s_ovf_q",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd13, 5'd17, 1'b1, 32'h8000_0000);
    run_op("s_ovf_r",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd14, 5'd18, 1'b1, 32'd0);
    // No register write: done still pulses, wr_en_div stays low
    run_op("no_wr",      32'd1000, 32'd10, 1'b0, 1'b0, 5'd15, 5'd19, 1'b0, 32'd100);

    // Back-to-back: second start raised in the done_div cycle
    @(negedge clk);
    drive(32'd1000, 32'd10, 1'b0, 1'b0, 5'd20, 5'd21, 1'b1);
    @(negedge clk);
    release_start();
    wait_done("b2b_first");
    if (got) begin
      check("b2b_first_result", bus.result, 32'd100);
      drive(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0, 5'd22, 5'd23, 1'b1);
      @(negedge clk);
      release_start();
      wait_done("b2b_second");
      if (got) begin
        check("b2b_second_result",  bus.result, 32'h0FFF_FFFF);
        check("b2b_second_latency", 32'(lat), 32'd32);
      end
    end

    // start pulsed at E5 of a running op must be ignored
    @(negedge clk);
    drive(32'd50, 32'd5, 1'b0, 1'b0, 5'd24, 5'd25, 1'b1);
    @(negedge clk);
    release_start();
    repeat (4) @(negedge clk);
    drive(32'd999, 32'd1, 1'b0, 1'b0, 5'd26, 5'd27, 1'b1);
    @(negedge clk);
    release_start();
    wait_done("ign");
    if (got) begin
      check("ign_result",  bus.result, 32'd10);
      check("ign_tag",     {27'd0, bus.dst_tag_div}, 32'd24);
      check("ign_latency", 32'(lat), 32'd27);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_div) dones++;
    end
    check("ign_no_extra_done", 32'(dones), 32'd0);

    // Asynchronous reset at E10 aborts the operation
    @(negedge clk);
    drive(32'd77, 32'd1, 1'b0, 1'b0, 5'd28, 5'd29, 1'b1);
    @(negedge clk);
    release_start();
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy",   {31'd0, bus.busy},        32'd0);
    check("arst_done",   {31'd0, bus.done_div},    32'd0);
    check("arst_wr",     {31'd0, bus.wr_en_div},   32'd0);
    check("arst_result", bus.result,               32'd0);
    check("arst_tag",    {27'd0, bus.dst_tag_div}, 32'd0);
    check("arst_dst",    {27'd0, bus.dst_div},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_div) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    run_op("post_rst", 32'd9, 32'd3, 1'b0, 1'b0, 5'd30, 5'd31, 1'b1, 32'd3);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
